// File: rtl/clock_div_bank_if.sv
// Divisor-update handshake bundle for clock_div_bank.
// Defining CLOCK_DIV_BANK_PHASE_EN adds cfg_phase alongside cfg_div.
interface clock_div_bank_if #(
  parameter int DIV_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [3:0]       cfg_sel;
  logic [DIV_W-1:0] cfg_div;
`ifdef CLOCK_DIV_BANK_PHASE_EN
  logic [DIV_W-1:0] cfg_phase;

  modport master (output cfg_valid, output cfg_sel, output cfg_div, output cfg_phase,
                  input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_sel, input  cfg_div, input  cfg_phase,
                  output cfg_ready);
`else
  modport master (output cfg_valid, output cfg_sel, output cfg_div, input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_sel, input  cfg_div, output cfg_ready);
`endif
endinterface

// File: rtl/clock_div_bank.sv
// Bank of programmable integer clock dividers with a shared lock/settle sequencer.
// Optional CLOCK_DIV_BANK_PHASE_EN: per-channel start phase loaded with each divisor.
module clock_div_bank #(
  parameter int NUM_CLKS    = 2,
  parameter int DIV_W       = 8,
  parameter int DEF_DIV     = 2,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                refclk,
  input  logic                rst_n,
  clock_div_bank_if.slave     cfg,
  output logic [NUM_CLKS-1:0] outclk,
  output logic [NUM_CLKS-1:0] ce,
  output logic                locked
);

  localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [4:0] NUM_SEL = 5'(NUM_CLKS);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    LOCKED    = 2'd1,
    RELOAD    = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [LCW-1:0]   lock_cnt, lock_next;
  logic [DIV_W-1:0] div_q    [NUM_CLKS];
  logic [DIV_W-1:0] preset   [NUM_CLKS];
  logic [DIV_W-1:0] cnt      [NUM_CLKS];
  logic [DIV_W-1:0] cnt_next [NUM_CLKS];
  logic [NUM_CLKS-1:0] outclk_next, ce_next;
  logic             hs;
  logic             sel_ok;
  logic [DIV_W-1:0] div_wr;

  assign sel_ok = {1'b0, cfg.cfg_sel} < NUM_SEL;
  assign div_wr = (cfg.cfg_div == '0) ? DIV_W'(1) : cfg.cfg_div;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_LOCK;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    hs            = 1'b0;
    cfg.cfg_ready = 1'b0;
    locked        = 1'b0;
    case (state)
      WAIT_LOCK: if (lock_cnt == LCW'(LOCK_CYCLES - 1)) state_next = LOCKED;
      LOCKED: begin
        cfg.cfg_ready = 1'b1;
        locked        = 1'b1;
        hs            = cfg.cfg_valid;
        if (hs && sel_ok) state_next = RELOAD;
      end
      RELOAD:  state_next = WAIT_LOCK;
      default: state_next = WAIT_LOCK;
    endcase
  end

  // Outputs are registered from next-cycle counter values, so the first LOCKED
  // cycle already shows each channel at its preset.
  always_comb begin
    lock_next = '0;
    if (state == WAIT_LOCK && state_next == WAIT_LOCK) lock_next = lock_cnt + 1'b1;
    for (int unsigned i = 0; i < NUM_CLKS; i++) begin
      cnt_next[i] = preset[i];
      if (state == LOCKED && state_next == LOCKED)
        cnt_next[i] = (cnt[i] == div_q[i] - 1'b1) ? '0 : cnt[i] + 1'b1;
      outclk_next[i] = (state_next == LOCKED) &&
                       (cnt_next[i] < ((div_q[i] >> 1) + {{(DIV_W-1){1'b0}}, div_q[i][0]}));
      ce_next[i]     = (state_next == LOCKED) && (cnt_next[i] == div_q[i] - 1'b1);
    end
  end

`ifndef CLOCK_DIV_BANK_PHASE_EN
  always_comb begin
    for (int unsigned i = 0; i < NUM_CLKS; i++) preset[i] = '0;
  end
`endif

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt <= '0;
      outclk   <= '0;
      ce       <= '0;
      for (int unsigned i = 0; i < NUM_CLKS; i++) begin
        div_q[i] <= DIV_W'(DEF_DIV);
        cnt[i]   <= '0;
`ifdef CLOCK_DIV_BANK_PHASE_EN
        preset[i] <= '0;
`endif
      end
    end else begin
      lock_cnt <= lock_next;
      outclk   <= outclk_next;
      ce       <= ce_next;
      for (int unsigned i = 0; i < NUM_CLKS; i++) begin
        cnt[i] <= cnt_next[i];
        if (hs && sel_ok && cfg.cfg_sel == 4'(i)) begin
          div_q[i] <= div_wr;
`ifdef CLOCK_DIV_BANK_PHASE_EN
          preset[i] <= cfg.cfg_phase % div_wr;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_div_bank.sv
// Directed + randomized bench for clock_div_bank against a period/phase arithmetic model.
// Builds with or without CLOCK_DIV_BANK_PHASE_EN.
module tb_clock_div_bank;
  localparam int NUM_CLKS    = 2;
  localparam int DIV_W       = 8;
  localparam int DEF_DIV     = 2;
  localparam int LOCK_CYCLES = 16;

  logic                refclk = 1'b0;
  logic                rst_n  = 1'b0;
  logic [NUM_CLKS-1:0] outclk, ce;
  logic                locked;

  clock_div_bank_if #(.DIV_W(DIV_W)) cfg_if ();

  clock_div_bank #(
    .NUM_CLKS(NUM_CLKS), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .cfg(cfg_if),
    .outclk(outclk), .ce(ce), .locked(locked)
  );

  always #5 refclk = ~refclk;

  int errors = 0;
  int checks = 0;

  // Model: channel i in lock cycle t sits at phase (pre+t) mod div.
  int m_div [NUM_CLKS];
  int m_pre [NUM_CLKS];
  bit m_locked;
  int m_wait;
  int m_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [NUM_CLKS-1:0] eo, ec;
    int pos;
    eo = '0;
    ec = '0;
    for (int i = 0; i < NUM_CLKS; i++) begin
      if (m_locked) begin
        pos   = (m_pre[i] + m_t) % m_div[i];
        eo[i] = (pos < (m_div[i] + 1) / 2);
        ec[i] = (pos == m_div[i] - 1);
      end
    end
    chk("outclk",    32'(outclk),           32'(eo));
    chk("ce",        32'(ce),               32'(ec));
    chk("locked",    32'(locked),           32'(m_locked));
    chk("cfg_ready", 32'(cfg_if.cfg_ready), 32'(m_locked));
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CLKS; i++) begin
      m_div[i] = DEF_DIV;
      m_pre[i] = 0;
    end
    m_locked = 1'b0;
    m_wait   = LOCK_CYCLES;
    m_t      = 0;
  endtask

  task automatic model_tick();
    if (m_locked) m_t++;
    else begin
      m_wait--;
      if (m_wait == 0) begin
        m_locked = 1'b1;
        m_t      = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      tick();
      model_tick();
      check_all();
    end
  endtask

  // Requester holds cfg_valid until the handshake, within a cycle budget.
  task automatic write_cfg(input int sel, input int dv, input int ph);
    bit done;
    int d;
    done = 1'b0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_sel   = 4'(sel);
    cfg_if.cfg_div   = DIV_W'(dv);
`ifdef CLOCK_DIV_BANK_PHASE_EN
    cfg_if.cfg_phase = DIV_W'(ph);
`endif
    for (int k = 0; k < 64 && !done; k++) begin
      if (m_locked) begin
        tick();
        if (sel < NUM_CLKS) begin
          d = (dv == 0) ? 1 : dv;
          m_div[sel] = d;
`ifdef CLOCK_DIV_BANK_PHASE_EN
          m_pre[sel] = ph % d;
`else
          m_pre[sel] = 0;
`endif
          m_locked = 1'b0;
          m_wait   = LOCK_CYCLES + 1;
        end else begin
          m_t++;
        end
        done = 1'b1;
      end else begin
        tick();
        model_tick();
      end
      check_all();
    end
    cfg_if.cfg_valid = 1'b0;
    chk("write_done", 32'(done), 32'd1);
  endtask

  task automatic pulse_reset(input int n);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (n) begin
      tick();
      check_all();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_sel   = '0;
    cfg_if.cfg_div   = '0;
`ifdef CLOCK_DIV_BANK_PHASE_EN
    cfg_if.cfg_phase = '0;
`endif
    model_reset();
    #3;
    check_all();
    repeat (2) begin
      tick();
      check_all();
    end
    rst_n = 1'b1;

    // Lock on the 16th edge, then default divide-by-2 on both channels.
    run(LOCK_CYCLES + 8);

    // Divisor 5 on channel 1, relock after 17 cycles.
    write_cfg(1, 5, 0);
    run(LOCK_CYCLES + 1 + 12);

    // Out-of-range select: handshake completes, nothing disturbed.
    write_cfg(7, 9, 0);
    run(6);

    // Divisor 0 stored as 1: constant high outclk and ce.
    write_cfg(0, 0, 0);
    run(LOCK_CYCLES + 1 + 8);

    // Largest divisor, observed across its wrap.
    write_cfg(1, 255, 0);
    run(LOCK_CYCLES + 1 + 300);

    // Asynchronous reset while locked with outclk[0] high.
    pulse_reset(2);
    run(LOCK_CYCLES + 2);

    // Request raised during WAIT_LOCK is held until the sequencer locks.
    pulse_reset(1);
    run(3);
    write_cfg(0, 5, 0);
    run(8);
    pulse_reset(2);
    run(LOCK_CYCLES + 6);

    // Phase offset on channel 1 (zero preset when phase feature is absent).
    write_cfg(1, 4, 2);
    run(LOCK_CYCLES + 1 + 8);

    repeat (12) begin
      write_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 12)), int'($urandom_range(0, 15)));
      run(int'($urandom_range(0, 30)));
    end
    run(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_div_bank.md
CLOCK_DIV_BANK -- requirements
Module: clock_div_bank

Interface
REQ-001 SHALL provide parameter NUM_CLKS, default 2, number of output clock channels (1..16).
REQ-002 SHALL provide parameter DIV_W, default 8, divisor width in bits.
REQ-003 SHALL provide parameter DEF_DIV, default 2, divisor loaded into every channel at reset.
REQ-004 SHALL provide parameter LOCK_CYCLES, default 16, settle delay in refclk cycles (>=1).
REQ-005 SHALL have one clock and an asynchronous, active-low reset, named as below.
REQ-006 SHALL have port refclk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port cfg_valid  input  1  divisor update request.
REQ-009 SHALL have port cfg_ready  output  1  update accepted when high with cfg_valid.
REQ-010 SHALL have port cfg_sel  input  4  channel index for the update.
REQ-011 SHALL have port cfg_div  input  DIV_W  new divisor.
REQ-012 SHALL have port outclk  output  NUM_CLKS  divided clocks, registered.
REQ-013 SHALL have port ce  output  NUM_CLKS  one-cycle clock-enable strobes, registered.
REQ-014 SHALL have port locked  output  1  all channels running and aligned.

Function
REQ-015 SHALL implement states WAIT_LOCK, LOCKED, RELOAD; cfg_ready=1 only in LOCKED.
REQ-016 WAIT_LOCK: lock counter counts LOCK_CYCLES cycles, then -> LOCKED; channel counters held at preset.
REQ-017 LOCKED: locked=1; each channel counter counts 0..div-1 and wraps to 0.
REQ-018 In LOCKED, outclk[i]=1 for the first ceil(div/2) cycles of each period, 0 for the remaining floor(div/2).
REQ-019 In LOCKED, ce[i]=1 exactly in the cycle whose counter value is div-1; div=1 gives ce[i] constantly 1 and outclk[i] constantly 1.
REQ-020 First LOCKED cycle: every channel counter = preset, so all channels with equal preset rise together.
REQ-021 Outside LOCKED: outclk=0, ce=0, locked=0.
REQ-022 Handshake cfg_valid&cfg_ready with cfg_sel<NUM_CLKS: store divisor, next state RELOAD.
REQ-023 cfg_div=0 SHALL be stored as 1.
REQ-024 cfg_sel>=NUM_CLKS: handshake completes, divisor ignored, state stays LOCKED, no output disturbance.
REQ-025 RELOAD lasts exactly 1 cycle, clears all channel counters to preset and lock counter to 0, then -> WAIT_LOCK.
REQ-026 locked SHALL rise exactly 1+LOCK_CYCLES cycles after an accepted reconfiguration handshake.
REQ-027 cfg_valid outside LOCKED SHALL be ignored with no state effect; requester holds it until cfg_ready.
REQ-028 Divisor comparisons SHALL use DIV_W-bit unsigned arithmetic; div=2^DIV_W-1 supported without overflow.

Reset
REQ-029 rst_n low SHALL asynchronously force: state WAIT_LOCK, lock counter 0, channel counters preset, all divisors DEF_DIV, outclk=0, ce=0, locked=0, cfg_ready=0.
REQ-030 After rst_n deasserts, locked SHALL rise on the LOCK_CYCLES-th rising edge of refclk.
REQ-031 Reset mid-RELOAD or mid-WAIT_LOCK SHALL discard progress; accepted divisors revert to DEF_DIV.

Configuration
REQ-032 Macro CLOCK_DIV_BANK_PHASE_EN SHALL, when defined, add input cfg_phase (DIV_W) stored with cfg_div; channel preset = cfg_phase mod div (reset preset 0).
REQ-033 Without CLOCK_DIV_BANK_PHASE_EN, cfg_phase SHALL be absent and all presets SHALL be 0.

Verification
REQ-034 Reset release, defaults (NUM_CLKS=2, DEF_DIV=2, LOCK_CYCLES=16) -> locked rises on edge 16; both outclk toggle 1,0,1,0 in phase; ce high every second cycle.
REQ-035 In LOCKED write cfg_sel=1, cfg_div=5 -> cfg_ready drops next cycle, locked low 17 cycles, then outclk[1] pattern 1,1,1,0,0, ce[1] on 5th cycle, channels rise together.
REQ-036 cfg_div=0 on channel 0 -> after relock outclk[0]=1 and ce[0]=1 continuously.
REQ-037 cfg_sel=7 with NUM_CLKS=2 -> handshake in one cycle, locked stays 1, outputs uninterrupted.
REQ-038 rst_n pulsed low 8 cycles into WAIT_LOCK after divisor 5 written -> outputs 0 immediately, relock at edge 16 with divisor 2.
REQ-039 With CLOCK_DIV_BANK_PHASE_EN, cfg_div=4, cfg_phase=2 on channel 1 -> first LOCKED cycles outclk[1]=0,0,1,1 while outclk[0]=1,0.
